// File: rtl/uart_xcvr.sv
// uart_xcvr: independent UART transmitter and receiver on one clock, LSB first, idle-high line.
// Define UART_PARITY_EN to add a parity bit per frame (even, or odd when PARITY_ODD=1).
module uart_xcvr #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
    // state    | meaning
    // S_IDLE   | line idle; TX accepts data, RX waits for a falling edge
    // S_START  | start bit
    // S_DATA   | payload bits, LSB first
    // S_PARITY | parity bit (UART_PARITY_EN only)
    // S_STOP   | stop bit(s)
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LOAD     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD    = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [2:0]       LAST_BIT     = 3'(DATA_BITS - 1);
    localparam logic             PAR_SENSE    = 1'(PARITY_ODD);

    state_t               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]           tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 tx_q, tx_d, tx_ready_q, tx_ready_d;
    logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    logic                 rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
    logic                 rx_pbit_q, rx_pbit_d, rx_perr_q, rx_perr_d;
`endif

    // The payload register rotates, so its XOR still covers the whole word at the last bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q == '0) ? tx_cnt_q : tx_cnt_q - CNT_ONE;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = BIT_LOAD;
                    tx_shift_d = tx_data;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            S_START: if (tx_cnt_q == '0) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = BIT_LOAD;
                tx_idx_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d   = BIT_LOAD;
                tx_idx_d   = tx_idx_q + 3'd1;
                tx_shift_d = {tx_shift_q[0], tx_shift_q[DATA_BITS-1:1]};
                tx_d       = tx_shift_q[1];
                if (tx_idx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    tx_state_d = S_PARITY;
                    tx_d       = (^tx_shift_q) ^ PAR_SENSE;
`else
                    tx_state_d = S_STOP;
                    tx_cnt_d   = STOP_LOAD;
                    tx_d       = 1'b1;
`endif
                end
            end
            S_PARITY: if (tx_cnt_q == '0) begin
                tx_state_d = S_STOP;
                tx_cnt_d   = STOP_LOAD;
                tx_d       = 1'b1;
            end
            S_STOP: if (tx_cnt_q == '0) begin
                tx_state_d = S_IDLE;
                tx_ready_d = 1'b1;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // A start needs a high-to-low edge, so a line held low after a bad stop bit cannot retrigger.
    always_comb begin
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_cnt_q == '0) ? rx_cnt_q : rx_cnt_q - CNT_ONE;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
`ifdef UART_PARITY_EN
        rx_pbit_d  = rx_pbit_q;
        rx_perr_d  = rx_perr_q;
`endif
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_sync_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = HALF_LOAD;
            end
            S_START: if (rx_cnt_q == '0) begin
                if (rx_sync_q) begin
                    rx_state_d = S_IDLE;
                end else begin
                    rx_state_d = S_DATA;
                    rx_cnt_d   = BIT_LOAD;
                    rx_idx_d   = '0;
                end
            end
            S_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BIT_LOAD;
                rx_idx_d   = rx_idx_q + 3'd1;
                rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_idx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    rx_state_d = S_PARITY;
`else
                    rx_state_d = S_STOP;
`endif
                end
            end
            S_PARITY: if (rx_cnt_q == '0) begin
`ifdef UART_PARITY_EN
                rx_pbit_d  = rx_sync_q;
`endif
                rx_state_d = S_STOP;
                rx_cnt_d   = BIT_LOAD;
            end
            S_STOP: if (rx_cnt_q == '0) begin
                rx_state_d = S_IDLE;
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                rx_ferr_d  = !rx_sync_q;
`ifdef UART_PARITY_EN
                rx_perr_d  = (^rx_shift_q) ^ rx_pbit_q ^ PAR_SENSE;
`endif
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_pbit_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_pbit_q  <= rx_pbit_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = tx_ready_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    // No parity bit on the line, so the flag can never assert.
    assign rx_parity_err = PAR_SENSE & 1'b0;
`endif
endmodule

// File: tb/tb_uart_xcvr.sv
`timescale 1ns/1ps
// Bench for uart_xcvr at 100 MHz / 115200 baud, 8 data bits, 1 stop bit (868 clocks per bit).
module tb_uart_xcvr;
    localparam int CPB = 868;
`ifdef UART_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int NBITS     = 10 + NPAR;
    localparam int FRAME_CYC = NBITS * CPB;
    localparam bit PAR_ODD   = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n, rx_drv, loop_en, rx_line;
    logic       tx, tx_valid, tx_ready, rx_valid, rx_frame_err, rx_parity_err;
    logic [7:0] tx_data, rx_data;
    int         errors = 0;
    int         checks = 0;

    typedef struct packed { logic [7:0] d; logic fe; logic pe; } rx_evt_t;
    rx_evt_t rx_evts[$];

    assign rx_line = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_xcvr #(
        .CLK_FREQ(100000000), .BAUD(115200), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_evts.push_back({rx_data, rx_frame_err, rx_parity_err});
    end

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: observed no finish after 150000 cycles, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Line level of bit k of a frame: start, data LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int k, input bit flip);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NPAR == 1 && k == 9) return (^d) ^ PAR_ODD ^ flip;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit hold, output int waited);
        int mism = 0;
        int busy = 0;
        logic exp;
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 2 * FRAME_CYC) begin
            @(negedge clk);
            waited++;
        end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = ~d;
        if (!hold) tx_valid = 1'b0;
        for (int n = 1; n <= FRAME_CYC; n++) begin
            exp = frame_bit(d, (n - 1) / CPB, 1'b0);
            if (tx !== exp) mism++;
            if (tx_ready !== 1'b0) busy++;
            if ((n - 1) % CPB == CPB / 2)
                chk($sformatf("tx_%02h_bit%0d", d, (n - 1) / CPB), tx, exp);
            @(negedge clk);
        end
        chk($sformatf("tx_%02h_cycle_mism", d), mism, 0);
        chk($sformatf("tx_%02h_ready_busy", d), busy, 0);
        chk($sformatf("tx_%02h_ready_after", d), tx_ready, 1);
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic stop_val, input bit flip);
        for (int k = 0; k < NBITS; k++) begin
            rx_drv = (k == NBITS - 1) ? stop_val : frame_bit(d, k, flip);
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        rx_evt_t e;
        int waited = 0;
        while (rx_evts.size() == 0 && waited < 2 * CPB) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, rx_evts.size() > 0, 1);
        if (rx_evts.size() > 0) begin
            e = rx_evts.pop_front();
            chk({tag, "_data"}, e.d, d);
            chk({tag, "_frame_err"}, e.fe, fe);
            chk({tag, "_parity_err"}, e.pe, pe);
        end
    endtask

    initial begin
        logic [7:0] r1, r2, r3;
        int w, lows;
        rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        chk("rst_parity_err", rx_parity_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_edge", tx_ready, 1);

        loop_en = 1'b1;
        send_frame(8'h55, 1'b0, w);
        check_rx("lb_55", 8'h55, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, w);
        send_frame(8'h0A, 1'b0, w);
        chk("b2b_extra_wait", w, 0);
        check_rx("lb_A5", 8'hA5, 1'b0, 1'b0);
        check_rx("lb_0A", 8'h0A, 1'b0, 1'b0);
        chk("lb_event_count", rx_evts.size(), 0);

        loop_en = 1'b0;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        fork
            send_frame(r1, 1'b0, w);
            begin
                drive_rx_frame(8'hFF, 1'b0, 1'b0);
                repeat (5 * CPB) @(negedge clk);
            end
        join
        check_rx("frame_err_FF", 8'hFF, 1'b1, 1'b0);
        chk("break_no_restart", rx_evts.size(), 0);

        fork
            send_frame(r2, 1'b0, w);
            begin
                rx_drv = 1'b1;
                repeat (2 * CPB) @(negedge clk);
                rx_drv = 1'b0;
                repeat (300) @(negedge clk);
                rx_drv = 1'b1;
                repeat (2 * CPB) @(negedge clk);
                chk("glitch_no_valid", rx_evts.size(), 0);
                drive_rx_frame(8'h3C, 1'b1, 1'b0);
            end
        join
        check_rx("after_glitch_3C", 8'h3C, 1'b0, 1'b0);

`ifdef UART_PARITY_EN
        drive_rx_frame(8'h07, 1'b1, 1'b1);
        check_rx("parity_bad_07", 8'h07, 1'b0, 1'b1);
        drive_rx_frame(8'h07, 1'b1, 1'b0);
        check_rx("parity_good_07", 8'h07, 1'b0, 1'b0);
`endif

        chk("ready_before_rst", tx_ready, 1);
        tx_data  = r3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        chk("pre_rst_start_low", tx, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_tx_ready", tx_ready, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
        lows = 0;
        for (int n = 0; n < FRAME_CYC; n++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        chk("post_rst_no_residual", lows, 0);
        chk("post_rst_no_rx", rx_evts.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer truncation), minimum 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width, legal 5..8.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits sent, legal 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored unless UART_PARITY_EN is defined.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1, reset, synchronous to clk, active-low.
REQ-008 SHALL have port rx, input, 1, asynchronous serial input, idle high.
REQ-009 SHALL have port tx, output, 1, serial output, idle high, registered.
REQ-010 SHALL have port tx_data, input, DATA_BITS, byte to transmit.
REQ-011 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-012 SHALL have port tx_ready, output, 1, transmitter can accept.
REQ-013 SHALL have port rx_data, output, DATA_BITS, last received payload.
REQ-014 SHALL have port rx_valid, output, 1, one-cycle pulse, rx_data and error flags valid.
REQ-015 SHALL have port rx_frame_err, output, 1, stop bit sampled low on the current rx_valid.
REQ-016 SHALL have port rx_parity_err, output, 1, parity mismatch on the current rx_valid.

Function
REQ-017 TX FSM SHALL use states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, each bit lasting exactly CLKS_PER_BIT cycles.
REQ-018 tx_ready SHALL be high only in IDLE; transfer occurs on the cycle where tx_valid && tx_ready; tx_data is latched then, and tx goes low on the next cycle.
REQ-019 Data SHALL be sent LSB first; STOP holds tx high for STOP_BITS bit-times; tx_ready reasserts the cycle after STOP ends.
REQ-020 A tx_valid held high in IDLE SHALL start back-to-back frames with no idle gap beyond the one ready cycle.
REQ-021 rx SHALL pass through a 2-flop synchroniser before any use.
REQ-022 RX FSM SHALL use states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; IDLE leaves on synchronised rx high-to-low.
REQ-023 START SHALL resample at CLKS_PER_BIT/2; if rx is high the start is false, return to IDLE, no rx_valid.
REQ-024 Each subsequent bit SHALL be sampled once, CLKS_PER_BIT cycles after the previous sample (bit centre), shifted in LSB first.
REQ-025 At the first stop-bit sample the RX SHALL update rx_data, rx_frame_err, rx_parity_err and pulse rx_valid for one cycle, then return to IDLE (only one stop bit checked, regardless of STOP_BITS).
REQ-026 A frame with a framing error SHALL still deliver rx_data and rx_valid; rx_data and flags hold until the next rx_valid.
REQ-027 If rx stays low after a framing error, RX SHALL not restart until rx has been seen high (break protection).
REQ-028 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-029 While rst_n is low at a clk edge: tx = 1, tx_ready = 0, rx_valid = 0, rx_data = 0, both error flags = 0, both FSMs = IDLE, counters = 0, synchroniser flops = 1.
REQ-030 tx_ready SHALL go high on the first clk edge after rst_n goes high; a frame in progress when reset asserts is abandoned with no further output.

Configuration
REQ-031 With macro UART_PARITY_EN defined, TX SHALL insert one parity bit after the data (even or odd per PARITY_ODD over DATA_BITS), and RX SHALL check it and set rx_parity_err on mismatch.
REQ-032 Without UART_PARITY_EN, there SHALL be no PARITY state, frames SHALL carry no parity bit, and rx_parity_err SHALL be tied to 0.

Verification (CLK_FREQ=100000000, BAUD=115200, CLKS_PER_BIT=868)
REQ-033 TX 8'h55, 8N1: tx low at cycle 1 after handshake; bits are 1,0,1,0,1,0,1,0 every 868 cycles; tx_ready high again at 8681 cycles.
REQ-034 Loopback tx->rx of 8'hA5 then 8'h0A back-to-back: two rx_valid pulses, rx_data 8'hA5 then 8'h0A, flags 0.
REQ-035 rx glitch low for 300 cycles: no rx_valid, RX back in IDLE; the following valid 8'h3C frame is received correctly.
REQ-036 rx frame 8'hFF with stop bit driven low: rx_valid with rx_frame_err=1, rx_data=8'hFF; no new frame until rx is high.
REQ-037 With UART_PARITY_EN, PARITY_ODD=0, frame 8'h07 with parity bit 0: rx_parity_err=1; with parity 1: rx_parity_err=0.
REQ-038 rst_n low mid-TX frame for 1 cycle: tx=1 next cycle, tx_ready=1 the cycle after release, no residual bits emitted.
